// File: rtl/data_memory_if.sv
// Port-A load/store and port-B read bus of the data memory block.
// The master drives addresses, data and board inputs; the slave returns reads and GPIO.
interface data_memory_if #(
    parameter int WORD_W = 16,
    parameter int VEC_N  = 9
);
    logic                      memWrite;
    logic                      modeSel;
    logic [19:0]               address1;
    logic [19:0]               address2;
    logic [VEC_N*WORD_W-1:0]   data1;
    logic [3:0]                switches;
    logic [35:0]               gpio1;
    logic [35:0]               gpio2;
    logic [VEC_N*WORD_W-1:0]   qa;
    logic [WORD_W-1:0]         qb;

    modport master (
        output memWrite, modeSel, address1, address2, data1, switches, gpio1,
        input  gpio2, qa, qb
    );

    modport slave (
        input  memWrite, modeSel, address1, address2, data1, switches, gpio1,
        output gpio2, qa, qb
    );
endinterface

// File: rtl/data_memory.sv
// Data RAM plus memory-mapped GPIO/switches; scalar or 9-word vector port A,
// read-only scalar port B, registered reads with write-first forwarding.
module data_memory #(
    parameter int RAM_BASE  = 76,
    parameter int RAM_DEPTH = 8192,
    parameter int WORD_W    = 16,
    parameter int VEC_N     = 9
) (
    input logic         clk,
    input logic         rst,
    data_memory_if.slave bus
);
    localparam int AW = $clog2(RAM_DEPTH);
    localparam int DW = VEC_N * WORD_W;
    localparam logic [19:0] LO    = 20'(RAM_BASE);
    localparam logic [19:0] HI    = 20'(RAM_BASE + RAM_DEPTH);
    localparam logic [19:0] DEPTH = 20'(RAM_DEPTH);

    logic [WORD_W-1:0] mem [RAM_DEPTH];

    logic [DW-1:0]     qa_r, qa_n;
    logic [WORD_W-1:0] qb_r, qb_n;
    logic [35:0]       g2_r, g2_n;
    logic              we;
    logic              ram_hit;
    logic [19:0]       base;
    logic [5:0]        io_off;
    logic [19:0]       widx [VEC_N];
    logic [VEC_N-1:0]  wok;
    logic [WORD_W-1:0] rword;

    always_comb begin
        we      = bus.memWrite && rst;
        ram_hit = (bus.address1 >= LO) && (bus.address1 < HI);
        base    = bus.address1 - LO;
        io_off  = bus.address1[5:0] - 6'd36;
        for (int k = 0; k < VEC_N; k++) begin
            widx[k] = base + 20'(k);
            wok[k]  = ram_hit && (k == 0 || bus.modeSel) && (widx[k] < DEPTH);
        end

        g2_n = g2_r;
        if (we && bus.address1 < 20'd36)
            g2_n[bus.address1[5:0]] = bus.data1[0];

        // Reading through g2_n/data1 gives write-first behaviour on port A
        qa_n  = '0;
        rword = '0;
        unique case (1'b1)
            bus.address1 < 20'd36:
                qa_n[0] = g2_n[bus.address1[5:0]];
            bus.address1 >= 20'd36 && bus.address1 < 20'd72:
                qa_n[0] = bus.gpio1[io_off];
            bus.address1 == 20'd75:
                qa_n[3:0] = bus.switches;
            ram_hit: begin
                for (int k = 0; k < VEC_N; k++) begin
                    rword = we ? bus.data1[k*WORD_W +: WORD_W]
                               : mem[widx[k][AW-1:0]];
                    if (wok[k])
                        qa_n[k*WORD_W +: WORD_W] = rword;
                end
            end
            default: qa_n = '0;
        endcase

        qb_n = '0;
        if (bus.address2 < DEPTH)
            qb_n = mem[bus.address2[AW-1:0]];
        for (int k = 0; k < VEC_N; k++)
            if (we && wok[k] && widx[k] == bus.address2)
                qb_n = bus.data1[k*WORD_W +: WORD_W];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            qa_r <= '0;
            qb_r <= '0;
            g2_r <= '0;
        end else begin
            qa_r <= qa_n;
            qb_r <= qb_n;
            g2_r <= g2_n;
        end
    end

    // RAM contents survive reset; only the write strobe is gated by it
    always_ff @(posedge clk) begin
        for (int k = 0; k < VEC_N; k++)
            if (we && wok[k])
                mem[widx[k][AW-1:0]] <= bus.data1[k*WORD_W +: WORD_W];
    end

    assign bus.qa    = qa_r;
    assign bus.qb    = qb_r;
    assign bus.gpio2 = g2_r;
endmodule

// File: tb/tb_data_memory.sv
// Directed table-driven bench for data_memory, plus short hand-written
// sequences for GPIO read-during-write and live input sampling.
module tb_data_memory;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_memory_if bus ();

    data_memory dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic         rst;
        logic         we;
        logic         md;
        logic [19:0]  a1;
        logic [19:0]  a2;
        logic [143:0] d1;
        logic [3:0]   sw;
        logic [35:0]  g1;
        logic [143:0] qa;
        logic [15:0]  qb;
        logic [35:0]  g2;
        bit           cqb;
        bit           cg2;
    } vec_t;

    vec_t tv[$];
    int checks = 0;
    int errors = 0;

    logic [143:0] vec1, vend, vend_rd, ones;

    task automatic add(input logic r, we, md, input logic [19:0] a1, a2,
                       input logic [143:0] d1, input logic [3:0] sw,
                       input logic [35:0] g1, input logic [143:0] qa,
                       input logic [15:0] qb, input logic [35:0] g2,
                       input bit cqb, cg2);
        vec_t v;
        v.rst = r; v.we = we; v.md = md; v.a1 = a1; v.a2 = a2;
        v.d1 = d1; v.sw = sw; v.g1 = g1; v.qa = qa; v.qb = qb;
        v.g2 = g2; v.cqb = cqb; v.cg2 = cg2;
        tv.push_back(v);
    endtask

    task automatic apply(input logic r, we, md, input logic [19:0] a1, a2,
                         input logic [143:0] d1, input logic [3:0] sw,
                         input logic [35:0] g1);
        rst          = r;
        bus.memWrite = we;
        bus.modeSel  = md;
        bus.address1 = a1;
        bus.address2 = a2;
        bus.data1    = d1;
        bus.switches = sw;
        bus.gpio1    = g1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int id,
                       input logic [143:0] got, want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d]: got %h want %h", nm, id, got, want);
        end
    endtask

    initial begin
        ones = '1;
        for (int k = 0; k < 9; k++) begin
            vec1[k*16 +: 16] = 16'(k + 1);
            vend[k*16 +: 16] = 16'((k + 1) * 16'h11);
        end
        vend_rd = '0;
        vend_rd[63:0] = vend[63:0];

        bus.memWrite = 1'b0;
        bus.modeSel  = 1'b0;
        bus.address1 = '0;
        bus.address2 = '0;
        bus.data1    = '0;
        bus.switches = '0;
        bus.gpio1    = '0;

        //  rst we md  a1     a2    d1          sw       g1     qa        qb       g2          cqb cg2
        add(0, 0, 0, 75,    0,    0,          4'b1010, 0,     0,        0,       0,          1,  1);
        add(1, 0, 0, 75,    0,    0,          4'b1010, 0,     10,       0,       0,          0,  0);
        add(1, 1, 0, 5000,  0,    255,        4'b1010, 0,     255,      0,       0,          0,  0);
        add(1, 0, 0, 5000,  0,    27,         4'b1010, 0,     255,      0,       0,          0,  0);
        add(1, 1, 0, 30,    4924, 1,          4'b1010, 0,     1,        255,     36'd1<<30,  1,  1);
        add(1, 0, 0, 38,    4924, 0,          4'b1010, 4,     1,        255,     36'd1<<30,  1,  1);
        add(1, 0, 0, 37,    0,    0,          4'b1010, 4,     0,        0,       0,          0,  0);
        add(1, 1, 1, 100,   27,   vec1,       4'b1010, 4,     vec1,     4,       0,          1,  0);
        add(1, 0, 1, 100,   27,   0,          4'b1010, 4,     vec1,     4,       0,          1,  0);
        add(1, 1, 0, 75,    0,    ones,       4'b1010, 4,     10,       0,       0,          0,  0);
        add(1, 1, 0, 50,    0,    1,          4'b1010, 4,     0,        0,       36'd1<<30,  0,  1);
        add(1, 0, 0, 38,    0,    0,          4'b1010, 4,     1,        0,       0,          0,  0);
        add(1, 1, 0, 9000,  0,    16'hbeef,   4'b1010, 4,     0,        0,       0,          0,  0);
        add(1, 0, 0, 9000,  0,    0,          4'b1010, 4,     0,        0,       0,          0,  0);
        add(1, 0, 0, 5000,  4924, 0,          4'b1010, 4,     255,      255,     0,          1,  0);
        add(1, 1, 1, 8264,  8191, vend,       4'b1010, 4,     vend_rd,  16'h44,  0,          1,  0);
        add(1, 0, 0, 8267,  8192, 0,          4'b1010, 4,     16'h44,   0,       0,          1,  0);
        add(0, 1, 0, 5000,  4924, 7,          4'b1010, 4,     0,        0,       0,          1,  1);
        add(1, 0, 0, 5000,  4924, 0,          4'b1010, 4,     255,      255,     0,          1,  1);
        add(1, 0, 0, 30,    0,    0,          4'b1010, 4,     0,        0,       0,          0,  1);

        foreach (tv[i]) begin
            apply(tv[i].rst, tv[i].we, tv[i].md, tv[i].a1, tv[i].a2,
                  tv[i].d1, tv[i].sw, tv[i].g1);
            chk("qa", i, bus.qa, tv[i].qa);
            if (tv[i].cqb) chk("qb", i, 144'(bus.qb), 144'(tv[i].qb));
            if (tv[i].cg2) chk("gpio2", i, 144'(bus.gpio2), 144'(tv[i].g2));
        end

        // GPIO pin set then clear, write-first on each edge
        apply(1, 1, 0, 3, 0, 1, 4'b1010, 4);
        chk("gpio_set_qa", 0, bus.qa, 144'd1);
        chk("gpio_set_pin", 0, 144'(bus.gpio2), 144'(36'd8));
        apply(1, 1, 0, 3, 0, 0, 4'b1010, 4);
        chk("gpio_clr_qa", 0, bus.qa, 144'd0);
        chk("gpio_clr_pin", 0, 144'(bus.gpio2), 144'd0);

        // Switch change is seen on the very next edge
        apply(1, 0, 0, 75, 0, 0, 4'b0101, 4);
        chk("sw_live", 0, bus.qa, 144'd5);

        // Vector read straddling the RAM end, port B at first word
        apply(1, 0, 1, 8264, 8188, 0, 4'b0101, 4);
        chk("vec_end_qa", 0, bus.qa, vend_rd);
        chk("vec_end_qb", 0, 144'(bus.qb), 144'h11);

        // Vector mode in the I/O region behaves as scalar
        apply(1, 0, 1, 38, 0, 0, 4'b0101, 4);
        chk("vec_io_qa", 0, bus.qa, 144'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Data memory and memory-mapped I/O block for the processor datapath.
- Port A is the processor load/store port. It can write and read, in scalar (16-bit) or vector (144-bit = 9×16) mode.
- Port B is a read-only 16-bit port into the RAM, used by a secondary consumer such as a display or debug path.
- Port A's address space covers GPIO output pins, GPIO input pins, switches and RAM.

Parameters:
- RAM_BASE, 76, first port-A address mapped to RAM word 0.
- RAM_DEPTH, 8192, number of 16-bit RAM words.
- WORD_W, 16, RAM word width.
- VEC_N, 9, words per vector access (qa/data1 width = VEC_N*WORD_W = 144).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- memWrite  in  1  port-A write enable.
- modeSel  in  1  0 = scalar access, 1 = vector access.
- address1  in  20  port-A address (memory map below).
- address2  in  20  port-B RAM word index (no RAM_BASE offset).
- data1  in  144  port-A write data.
- switches  in  4  board switches.
- gpio1  in  36  GPIO input pins.
- gpio2  out  36  GPIO output pins (registered).
- qa  out  144  port-A registered read data.
- qb  out  16  port-B registered read data.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (rst=0 resets on the rising clk edge).
- Reset (rst=0 at a rising edge): qa=0, qb=0, gpio2=0. RAM contents are not cleared. Writes are suppressed during reset.
- Port-A memory map:
  - 0..35: gpio2 pin n (read/write). A write sets gpio2[n]=data1[0]; a read returns {143'b0, gpio2[n]}.
  - 36..71: gpio1 pin (n-36), read-only. A read returns {143'b0, gpio1[n-36]}; writes are ignored.
  - 72..74: reserved. Reads return 0; writes are ignored.
  - 75: switches, read-only. A read returns {140'b0, switches}.
  - RAM_BASE..RAM_BASE+RAM_DEPTH-1: RAM word (address1-RAM_BASE).
  - Above that range: reads return 0; writes are ignored.
- Scalar mode (modeSel=0):
  - RAM write stores data1[15:0].
  - RAM read returns the word zero-extended to 144 bits.
- Vector mode (modeSel=1), RAM region only:
  - Accesses words i..i+8, where i = address1-RAM_BASE.
  - data1[16k+15:16k] maps to word i+k.
  - Words past the RAM end: ignored on write, read as 0.
  - In I/O regions, modeSel is ignored (scalar behaviour applies).
- Latency:
  - address1 and address2 are sampled at a rising edge; qa and qb are valid after that edge (1-cycle registered read).
  - A write with memWrite=1 takes effect at the same edge.
- Read-during-write on port A (same edge, same address): write-first. qa returns the newly written data, including gpio2 pins.
- Port-B read of a word being written by port A on the same edge also returns the new data. Port-B address out of range gives qb=0.
- gpio1 and switches are sampled directly at the edge; no synchronizer is required inside this block.

Test Plan:
- Reset then switch read:
  - Stimulus: rst=0 for one edge, then rst=1; switches=4'b1010; address1=75, memWrite=0.
  - Required: qa==0 after the reset edge; qa==10 after the next edge.
- Scalar RAM write/read-back:
  - Stimulus: address1=5000, data1=255, memWrite=1 for one edge.
  - Required: qa==255 at that edge (write-first).
  - Then set memWrite=0 and data1=27: qa stays 255, showing no write occurs with memWrite low.
- GPIO output:
  - Stimulus: address1=30, data1=1, memWrite=1 for one edge.
  - Required: gpio2[30]==1 and qa==1.
  - Simultaneously, address2=4924: qb==255, reading the RAM word written via address 5000.
- GPIO input:
  - Stimulus: gpio1=36'd4, address1=38, memWrite=0.
  - Required: qa==1 after one edge.
  - With address1=37: qa==0.
- Vector mode:
  - Stimulus: modeSel=1, address1=100, data1 = nine words 1..9 (word k = k+1), memWrite=1; then read address1=100 with memWrite=0.
  - Required: qa equals the written vector.
  - With address2=27: qb==4.
- Protection:
  - Stimulus: writes to address1=75, address1=50, and address1 above the RAM range.
  - Required: switches, gpio1 and RAM are unchanged, and a read of the out-of-range address returns 0.
